// File: rtl/noc_inject_flit_fifo.sv
// noc_inject_flit_fifo: first-word-fall-through flit queue between the cpu flitizer and the router injection port
// Ports:
//   nocclk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                    synchronous clear of every queued flit
//   in_flit/in_valid/in_ready   write side, driven by the flitizer
//   out_flit/out_valid/out_ready read side, head flit toward the router
//   occupancy, almost_full   stored flit count and its DEPTH-1 threshold decode
module noc_inject_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             nocclk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [127:0]     in_flit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [127:0]     out_flit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occupancy,
    output logic             almost_full
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [127:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             push, pop;
    assign in_ready    = occupancy != OCC_W'(DEPTH);
    assign out_valid   = occupancy != '0;
    assign almost_full = occupancy >= OCC_W'(DEPTH - 1);
    assign out_flit    = mem[rd_ptr];
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            rd_ptr    <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            wr_ptr    <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            occupancy <= (push && !pop) ? occupancy + OCC_W'(1) :
                         (pop && !push) ? occupancy - OCC_W'(1) : occupancy;
        end
    end
    always_ff @(posedge nocclk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_flit;
    end
endmodule

// File: tb/tb_noc_inject_flit_fifo.sv
// tb_noc_inject_flit_fifo: randomized and directed checks of the flit FIFO against a queue model
module tb_noc_inject_flit_fifo;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);
    logic             nocclk = 0;
    logic             rst_n = 0;
    logic             flush = 0;
    logic [127:0]     in_flit = '0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [127:0]     out_flit;
    logic             out_valid;
    logic             out_ready = 0;
    logic [OCC_W-1:0] occupancy;
    logic             almost_full;
    logic [127:0]     q[$];
    int               n_tests = 0;
    int               n_fail = 0;
    noc_inject_flit_fifo #(.DEPTH(DEPTH)) dut (
        .nocclk(nocclk), .rst_n(rst_n), .flush(flush),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .almost_full(almost_full)
    );
    always #5 nocclk = ~nocclk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic check_outputs(input string tag);
        check({tag, ".occ"}, 128'(occupancy), 128'(q.size()));
        check({tag, ".out_valid"}, 128'(out_valid), 128'(q.size() != 0));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(q.size() != DEPTH));
        check({tag, ".almost_full"}, 128'(almost_full), 128'(q.size() >= DEPTH - 1));
        if (q.size() != 0)
            check({tag, ".out_flit"}, out_flit, q[0]);
    endtask
    function automatic logic [127:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic drive(input logic v, input logic r, input logic f);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_flit   = rnd_flit();
    endtask
    task automatic step(input string tag);
        bit do_push, do_pop;
        @(posedge nocclk);
        do_push = in_valid && q.size() != DEPTH;
        do_pop  = out_ready && q.size() != 0;
        if (flush)
            q.delete();
        else begin
            if (do_pop)
                void'(q.pop_front());
            if (do_push)
                q.push_back(in_flit);
        end
        #1;
        check_outputs(tag);
    endtask
    task automatic async_reset_pulse(input string tag);
        in_valid  = 0;
        out_ready = 0;
        flush     = 0;
        #2 rst_n = 0;
        q.delete();
        #1;
        check_outputs(tag);
        #1 rst_n = 1;
    endtask
    initial begin
        #2;
        check_outputs("reset");
        #10 rst_n = 1;
        step("idle");
        drive(1, 0, 0); step("push_a");
        drive(1, 0, 0); step("push_b");
        drive(0, 0, 0); step("hold_ab");
        step("hold_ab2");
        drive(1, 0, 0); step("fill3");
        drive(1, 0, 0); step("fill4");
        drive(1, 0, 0); step("full_hold1");
        step("full_hold2");
        out_ready = 1; step("full_pop");
        out_ready = 0; step("push5");
        drive(0, 1, 0);
        for (int i = 0; i < 6; i++) step("drain1");
        drive(1, 0, 0); step("occ2_a");
        drive(1, 0, 0); step("occ2_b");
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0); step("wrap");
        end
        drive(0, 1, 0);
        for (int i = 0; i < 3; i++) step("drain2");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0); step("pre_flush");
        end
        drive(1, 1, 1); step("flush");
        drive(0, 1, 0); step("post_flush");
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0); step("pre_rst");
        end
        async_reset_pulse("async_rst");
        drive(1, 0, 0); step("push_x");
        drive(0, 1, 0); step("pop_x");
        step("empty_x");
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            step("rand");
            if ($urandom_range(0, 99) == 0)
                async_reset_pulse("rand_rst");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_inject_flit_fifo.md
NOC_INJECT_FLIT_FIFO -- requirements
Module: noc_inject_flit_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of flit entries; power of two, >= 2.
REQ-002 Parameter OCC_W, default $clog2(DEPTH+1), width of occupancy.
REQ-003 nocclk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all queued flits.
REQ-006 in_flit  input  128 (types::flit_t)  flit from cpu_to_noc_flitizer (its pushed_flit).
REQ-007 in_valid  input  1  in_flit valid (flitizer pushed_flit_valid).
REQ-008 in_ready  output  1  FIFO can accept (drives flitizer pushed_flit_ready).
REQ-009 out_flit  output  128 (types::flit_t)  head flit toward router injection port.
REQ-010 out_valid  output  1  out_flit valid.
REQ-011 out_ready  input  1  router accepts out_flit.
REQ-012 occupancy  output  OCC_W  number of stored flits, 0..DEPTH.
REQ-013 almost_full  output  1  occupancy >= DEPTH-1.

Function
REQ-014 Push event SHALL be in_valid & in_ready at a rising edge; pop event SHALL be out_valid & out_ready at a rising edge.
REQ-015 in_ready SHALL equal (occupancy != DEPTH) and SHALL depend only on registered state, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL equal (occupancy != 0), registered-state only; out_flit SHALL equal storage[rd_ptr] (first-word fall-through).
REQ-017 Latency: a flit pushed at edge N SHALL appear on out_flit with out_valid=1 after edge N when the FIFO was empty; no same-cycle bypass.
REQ-018 Order SHALL be strictly FIFO; flits SHALL be neither duplicated, dropped (except flush) nor modified.
REQ-019 Push SHALL write storage[wr_ptr] and advance wr_ptr by 1 modulo DEPTH; pop SHALL advance rd_ptr by 1 modulo DEPTH.
REQ-020 occupancy update: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-021 Full (occupancy=DEPTH): in_ready=0, so no push even if a pop occurs the same edge; in_ready returns to 1 the cycle after the pop.
REQ-022 Empty (occupancy=0): out_valid=0; out_ready is ignored; out_flit value is don't-care.
REQ-023 While out_valid=1 and out_ready=0, out_flit SHALL stay stable and occupancy SHALL not decrease.
REQ-024 flush=1 at an edge SHALL set rd_ptr, wr_ptr, occupancy to 0, overriding any push or pop that edge; the flit offered that edge is discarded.
REQ-025 almost_full SHALL be a combinational decode of registered occupancy.
REQ-026 Storage array SHALL not be reset; only pointers and occupancy reset.

Reset
REQ-027 rst_n=0 SHALL immediately force rd_ptr=0, wr_ptr=0, occupancy=0, hence out_valid=0, in_ready=1, almost_full=0, independent of nocclk.
REQ-028 Reset asserted mid-operation SHALL discard all queued flits; first flit pushed after release SHALL be the first popped.
REQ-029 Deassertion of rst_n SHALL be synchronous-safe: no push/pop on the edge coincident with release.

Verification
REQ-030 Reset, then push flits A,B (out_ready=0) -> occupancy 0,1,2; out_valid=1 one cycle after A's push edge; out_flit=A stable.
REQ-031 DEPTH=4: push 4 flits, out_ready=0 -> occupancy=4, in_ready=0, almost_full=1 from occupancy 3; 5th flit held at input, not stored.
REQ-032 Full, in_valid=1 and out_ready=1 same cycle -> pop only, occupancy 3, in_ready=1 next cycle, then 5th flit accepted; output order 1..5.
REQ-033 Occupancy 2, push and pop same edge for 10 cycles with rd/wr pointer wrap -> occupancy stays 2, output order equals input order.
REQ-034 Occupancy 3, flush=1 with simultaneous push and pop -> next cycle occupancy=0, out_valid=0, in_ready=1; no flit emitted.
REQ-035 Occupancy 2, rst_n pulsed low between edges -> out_valid=0 and occupancy=0 immediately; next pushed flit X is first out.
